// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared op codes, FSM encoding and select-stepping helper for
//            the ALU operation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;

    // Highest op code reachable by stepping; the next press wraps to ADD
    localparam logic [2:0] SEL_WRAP = OP_DIV;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // NOP only appears out of reset; once stepping starts it cycles ADD..DIV
    function automatic logic [2:0] next_sel(input logic [2:0] cur);
        if (cur >= SEL_WRAP) begin
            return OP_ADD;
        end
        return cur + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronizes a raw button, debounces it and emits a one-cycle
//            event on each accepted rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Accept a new level only after it persists; any bounce restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync1 != r_stable) begin
            if (r_cnt == C_CNT_MAX) begin
                r_stable <= r_sync1;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // One-cycle event on the rising edge of the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Steps the ALU op code from a button, launches one operation per
//            go press with a start/done handshake, latches the result and
//            flags a sticky timeout when the datapath never answers.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int WIDTH           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_sel,
    input  logic               btn_go,
    input  logic               alu_ready,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [2:0]         sel,
    output logic               alu_start,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               error
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] C_TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_sel_evt;
    logic               w_go_evt;
    logic [2:0]         r_sel;
    logic [2*WIDTH-1:0] r_result;
    logic               r_error;
    logic [TW-1:0]      r_to_cnt;
    logic               w_launch;
    logic               w_step_sel;
    logic               w_issue;
    logic               w_latch;
    logic               w_timeout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_sel),
        .press   (w_sel_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_go),
        .press   (w_go_evt)
    );

    // Next-state decode and one-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_step_sel   = 1'b0;
        w_issue      = 1'b0;
        w_latch      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_launch   = w_go_evt && (r_sel != OP_NOP) && alu_ready;
                // A coincident go press takes priority and swallows the sel press
                w_step_sel = w_sel_evt && !w_go_evt;
                if (w_launch) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so it wins over a coincident timeout
                if (alu_done) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_to_cnt == C_TO_MAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Op select, timeout counter, result latch and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel    <= OP_NOP;
            r_result <= '0;
            r_error  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (w_step_sel) begin
                r_sel <= next_sel(r_sel);
            end
            if (w_issue) begin
                r_error  <= 1'b0;
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_latch) begin
                r_result <= alu_result;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign sel       = r_sel;
    assign alu_start = (r_state == ST_ISSUE);
    assign result    = r_result;
    assign busy      = (r_state != ST_IDLE);
    assign error     = r_error;

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Controller that sequences the shared ALU datapath from two front-panel buttons. `btn_sel` steps through the operation codes and `btn_go` launches one operation. The block performs a start/done handshake with the datapath, latches the result, and flags a timeout if the datapath never answers. It sits between the board button pins and the ALU, and owns the ALU `sel` and `start` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synced cycles required to accept a button level change (board build overrides to 500000).
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the block aborts.
- `WIDTH`, default 8: ALU operand width; the result is `2*WIDTH` bits.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_sel` in 1: raw asynchronous button; each press advances the op code.
- `btn_go` in 1: raw asynchronous button; each press launches the selected op.
- `alu_ready` in 1: datapath idle and able to accept a start.
- `alu_done` in 1: one-cycle pulse; `alu_result` is valid in the same cycle.
- `alu_result` in `2*WIDTH`: datapath result.
- `sel` out 3: op code. 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 MUL, 6 DIV. Code 7 is never driven.
- `alu_start` out 1: one-cycle start pulse to the datapath.
- `result` out `2*WIDTH`: last successfully completed result.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `error` out 1: sticky timeout flag.

## Operation
- Each button passes through a 2-FF synchronizer and then a debouncer.
  - The stable level updates only after the synced level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the stable level produces a one-cycle press event.
- Reset values: `sel`=0, `alu_start`=0, `result`=0, `busy`=0, `error`=0, FSM=IDLE, debouncer stable levels=0.
- `sel` stepping (IDLE only): a sel press moves 0→1, then n→n+1 up to 6, and 6 wraps to 1. A sel press while busy is dropped, not queued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: a go press with `sel`≠0 and `alu_ready`=1 moves to ISSUE. A go press with `sel`=0 or `alu_ready`=0 is ignored.
  - ISSUE: `alu_start`=1 for exactly this cycle. `error` clears and the timeout counter clears. Next state is WAIT.
  - WAIT: on `alu_done`=1, latch `result`←`alu_result` and go to DONE. If the timeout counter reaches `TIMEOUT_CYCLES-1` without done, set `error`=1, leave `result` unchanged, and go to IDLE.
  - DONE: one cycle, then IDLE.
- `sel` is frozen while `busy`=1.
- `error` stays high until the next ISSUE or reset.

## Timing
- Raw button rising edge to press event: `DEBOUNCE_CYCLES+3` cycles for a clean edge (2 synchronizer stages, `DEBOUNCE_CYCLES` of debounce, 1 for edge detect).
- A go event in cycle E gives `alu_start` high in cycle E+1 and `busy` high from E+1.
- A sel event in cycle E gives the new `sel` visible in cycle E+1.
- A done pulse in WAIT at cycle D gives updated `result` from D+1, `busy` high in D+1 (DONE), and `busy` low from D+2.
- Boundary conditions:
  - `alu_done` is sampled only in WAIT. A done arriving in ISSUE, DONE or IDLE is ignored.
  - A done pulse in the same cycle the timeout would fire: done wins, no error.
  - Sel and go events in the same IDLE cycle: go wins using the current `sel`, and the sel event is discarded.
  - Reset asserted mid-operation: all reset values apply from the next edge. A later `alu_done` from the aborted op is ignored.
  - A held button generates exactly one event. Release generates none.

## Structure
- Package `alu_seq_pkg` holds:
  - the op code constants (NOP through DIV);
  - the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - the wrap limit 6.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`) contains the synchronizer, debounce counter and rising-edge event output. It is instantiated twice, once per button.
- Top level contains `sel` stepping, the FSM, the timeout counter (width `$clog2(TIMEOUT_CYCLES)`) and the result register.

## Test plan
- Reset, then 7 clean sel presses: `sel` reads 1, 2, 3, 4, 5, 6, 1.
- `sel`=5, `alu_ready`=1, go press, datapath returns done 3 cycles after start with `alu_result`=16'h00A2:
  - `alu_start` is a single pulse;
  - `result`=16'h00A2;
  - `busy` high for 5 cycles;
  - `error`=0.
- `sel`=6, go press, datapath never answers: `error`=1 after `TIMEOUT_CYCLES` WAIT cycles, FSM returns to IDLE, `result` is unchanged. A following successful op clears `error`.
- `btn_sel` toggled every 2 cycles for 20 cycles, then held high: exactly one `sel` increment occurs.
- Go press with `sel`=0, and go press with `alu_ready`=0: no `alu_start`. Sel and go events in the same cycle: op launches with the old `sel`, and `sel` is unchanged.
- Reset asserted in WAIT, then a late `alu_done` with 16'hFFFF: outputs are at reset values and `result` stays 0.
